plru_state_updater: RTL and testbench

- Read-modify-write controller that owns one single-port distributed-RAM instance holding tree pseudo-LRU (PLRU) bits per cache set.
- Accepts lookup results (set, hit/miss, hit way) from the tag-compare stage.
- Reads the set's PLRU bits, computes the victim way on a miss, and writes the updated bits back.
- Also provides a sweep flush that zeroes all sets; it sits directly upstream of the LUTRAM and drives its access port.

---
 rtl/plru_state_updater_pkg.sv | 14 +
 rtl/plru_state_updater_if.sv | 41 ++++
 rtl/plru_state_updater_tree_logic.sv | 45 ++++
 rtl/plru_state_updater.sv | 134 +++++++++++++
 tb/tb_plru_state_updater.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plru_state_updater_pkg.sv
// Shared types and helpers for the PLRU read-modify-write controller.
package plru_state_updater_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_FLUSH  = 2'd2
  } plru_state_e;

  function automatic int unsigned plru_width(input int unsigned ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/plru_state_updater_if.sv
// Request/response, flush and LUTRAM access signals of the PLRU updater.
interface plru_state_updater_if
  import plru_state_updater_pkg::*;
#(
  parameter int unsigned SET_PTR_WIDTH_IN_BITS = 6,
  parameter int unsigned WAY_PTR_WIDTH_IN_BITS = 2,
  parameter int unsigned PLRU_WIDTH_IN_BITS    = plru_width(4)
) ();

  logic                             req_valid_in;
  logic                             req_ready_out;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] req_set_in;
  logic                             req_hit_in;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] req_way_in;
  logic                             resp_valid_out;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] resp_way_out;
  logic                             flush_in;
  logic                             flush_done_out;
  logic                             lutram_access_en_out;
  logic                             lutram_write_en_out;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] lutram_set_addr_out;
  logic [PLRU_WIDTH_IN_BITS-1:0]    lutram_write_element_out;
  logic [PLRU_WIDTH_IN_BITS-1:0]    lutram_read_element_in;

  modport slave (
    input  req_valid_in, req_set_in, req_hit_in, req_way_in, flush_in,
           lutram_read_element_in,
    output req_ready_out, resp_valid_out, resp_way_out, flush_done_out,
           lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
           lutram_write_element_out
  );

  modport master (
    output req_valid_in, req_set_in, req_hit_in, req_way_in, flush_in,
           lutram_read_element_in,
    input  req_ready_out, resp_valid_out, resp_way_out, flush_done_out,
           lutram_access_en_out, lutram_write_en_out, lutram_set_addr_out,
           lutram_write_element_out
  );

endinterface

// File: rtl/plru_state_updater_tree_logic.sv
// Combinational heap-indexed tree PLRU: victim selection and access update.
module plru_tree_logic
  import plru_state_updater_pkg::*;
#(
  parameter int unsigned NUMBER_WAYS           = 4,
  parameter int unsigned WAY_PTR_WIDTH_IN_BITS = $clog2(NUMBER_WAYS),
  parameter int unsigned PLRU_WIDTH_IN_BITS    = plru_width(NUMBER_WAYS)
) (
  input  logic [PLRU_WIDTH_IN_BITS-1:0]    tree_bits_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0] access_way_in,
  output logic [WAY_PTR_WIDTH_IN_BITS-1:0] victim_way_out,
  output logic [PLRU_WIDTH_IN_BITS-1:0]    updated_bits_out
);

  localparam int unsigned LEVELS = WAY_PTR_WIDTH_IN_BITS;

  // Victim and update walks live in separate blocks so the caller may feed
  // the victim back in as the access way without a combinational loop.
  always_comb begin
    int unsigned v_node;
    logic        v_bit;
    victim_way_out = '0;
    v_node         = 0;
    v_bit          = 1'b0;
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      v_bit                            = tree_bits_in[v_node];
      victim_way_out[LEVELS - 1 - lvl] = v_bit;
      v_node                           = 2 * v_node + 1 + (v_bit ? 1 : 0);
    end
  end

  always_comb begin
    int unsigned u_node;
    logic        u_bit;
    updated_bits_out = tree_bits_in;
    u_node           = 0;
    u_bit            = 1'b0;
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      u_bit                    = access_way_in[LEVELS - 1 - lvl];
      updated_bits_out[u_node] = ~u_bit;
      u_node                   = 2 * u_node + 1 + (u_bit ? 1 : 0);
    end
  end

endmodule

// File: rtl/plru_state_updater.sv
// Read-modify-write controller for per-set tree-PLRU bits held in a LUTRAM,
// with a sweep flush that zeroes every set.
module plru_state_updater
  import plru_state_updater_pkg::*;
#(
  parameter int unsigned NUMBER_WAYS           = 4,
  parameter int unsigned NUMBER_SETS           = 64,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SETS),
  parameter int unsigned WAY_PTR_WIDTH_IN_BITS = $clog2(NUMBER_WAYS),
  parameter int unsigned PLRU_WIDTH_IN_BITS    = plru_width(NUMBER_WAYS)
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  plru_state_updater_if.slave  bus
);

  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET =
    SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

  plru_state_e                      state_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] flush_cnt_q;
  logic                             pending_flush_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] cap_set_q;
  logic                             cap_hit_q;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] cap_way_q;
  logic                             resp_valid_q;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] resp_way_q;
  logic                             flush_done_q;

  logic                             flush_req;
  logic                             ready;
  logic                             accept;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] victim_way;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] eff_way;
  logic [PLRU_WIDTH_IN_BITS-1:0]    updated_bits;

  plru_tree_logic #(
    .NUMBER_WAYS           (NUMBER_WAYS),
    .WAY_PTR_WIDTH_IN_BITS (WAY_PTR_WIDTH_IN_BITS),
    .PLRU_WIDTH_IN_BITS    (PLRU_WIDTH_IN_BITS)
  ) u_tree (
    .tree_bits_in     (bus.lutram_read_element_in),
    .access_way_in    (eff_way),
    .victim_way_out   (victim_way),
    .updated_bits_out (updated_bits)
  );

  assign eff_way   = cap_hit_q ? cap_way_q : victim_way;
  assign flush_req = bus.flush_in | pending_flush_q;
  // reset_in gates ready so nothing is accepted or read while held in reset.
  assign ready     = (state_q == ST_IDLE) && !flush_req && reset_in;
  assign accept    = ready && bus.req_valid_in;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q         <= ST_IDLE;
      flush_cnt_q     <= '0;
      pending_flush_q <= 1'b0;
      cap_set_q       <= '0;
      cap_hit_q       <= 1'b0;
      cap_way_q       <= '0;
      resp_valid_q    <= 1'b0;
      resp_way_q      <= '0;
      flush_done_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush_req) begin
            state_q         <= ST_FLUSH;
            flush_cnt_q     <= '0;
            pending_flush_q <= 1'b0;
          end else if (bus.req_valid_in) begin
            cap_set_q <= bus.req_set_in;
            cap_hit_q <= bus.req_hit_in;
            cap_way_q <= bus.req_way_in;
            state_q   <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (bus.flush_in) pending_flush_q <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_way_q   <= eff_way;
          state_q      <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (bus.flush_in) pending_flush_q <= 1'b1;
          if (flush_cnt_q == LAST_SET) begin
            flush_done_q <= 1'b1;
            flush_cnt_q  <= '0;
            state_q      <= ST_IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.lutram_access_en_out     = 1'b0;
    bus.lutram_write_en_out      = 1'b0;
    bus.lutram_set_addr_out      = '0;
    bus.lutram_write_element_out = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bus.lutram_access_en_out = 1'b1;
          bus.lutram_set_addr_out  = bus.req_set_in;
        end
      end
      ST_UPDATE: begin
        bus.lutram_access_en_out     = 1'b1;
        bus.lutram_write_en_out      = 1'b1;
        bus.lutram_set_addr_out      = cap_set_q;
        bus.lutram_write_element_out = updated_bits;
      end
      ST_FLUSH: begin
        bus.lutram_access_en_out = 1'b1;
        bus.lutram_write_en_out  = 1'b1;
        bus.lutram_set_addr_out  = flush_cnt_q;
      end
      default: ;
    endcase
  end

  assign bus.req_ready_out  = ready;
  assign bus.resp_valid_out = resp_valid_q;
  assign bus.resp_way_out   = resp_way_q;
  assign bus.flush_done_out = flush_done_q;

endmodule

// File: tb/tb_plru_state_updater.sv
// Scoreboard bench for plru_state_updater with a behavioural LUTRAM.
module tb_plru_state_updater;

  localparam int unsigned SETS = 64;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int unsigned total;
  int unsigned bad;

  plru_state_updater_if #(
    .SET_PTR_WIDTH_IN_BITS (6),
    .WAY_PTR_WIDTH_IN_BITS (2),
    .PLRU_WIDTH_IN_BITS    (3)
  ) bus ();

  plru_state_updater #(
    .NUMBER_WAYS (4),
    .NUMBER_SETS (SETS)
  ) dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural LUTRAM with registered read data.
  logic [2:0] lut_mem [SETS];
  logic [2:0] lut_rd;
  assign bus.lutram_read_element_in = lut_rd;
  always @(posedge clk) begin
    if (bus.lutram_access_en_out) begin
      if (bus.lutram_write_en_out) lut_mem[bus.lutram_set_addr_out] <= bus.lutram_write_element_out;
      else lut_rd <= lut_mem[bus.lutram_set_addr_out];
    end
  end

  typedef struct {
    logic [1:0]  way;
    logic [5:0]  set;
    logic [2:0]  wdata;
    int unsigned cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] ref_mem [SETS];
  logic [5:0] last_wr_addr;
  logic [2:0] last_wr_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_victim(input logic [2:0] t);
    if (t[0]) return t[2] ? 2'd3 : 2'd2;
    else      return t[1] ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [2:0] ref_update(input logic [2:0] t, input logic [1:0] w);
    logic [2:0] n;
    n = t;
    case (w)
      2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  task automatic push_exp(input logic [5:0] set, input logic hit, input logic [1:0] way);
    exp_t e;
    logic [1:0] w;
    w = hit ? way : ref_victim(ref_mem[set]);
    ref_mem[set] = ref_update(ref_mem[set], w);
    e.way = w; e.set = set; e.wdata = ref_mem[set]; e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  // Response monitor: compares each response and the write that preceded it.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid_out) begin
      if (sb_q.size() == 0) check_val("resp_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("resp_way", bus.resp_way_out, e.way);
        check_val("wr_addr", last_wr_addr, e.set);
        check_val("wr_data", last_wr_data, e.wdata);
        check_val("latency", cyc - e.cyc, 2);
      end
    end
    if (bus.lutram_access_en_out && bus.lutram_write_en_out) begin
      last_wr_addr = bus.lutram_set_addr_out;
      last_wr_data = bus.lutram_write_element_out;
    end
  end

  task automatic send_req(input logic [5:0] set, input logic hit, input logic [1:0] way);
    bit done;
    done = 0;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b1; bus.req_set_in = set; bus.req_hit_in = hit; bus.req_way_in = way;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready_out) begin
        push_exp(set, hit, way);
        done = 1;
      end
    end
    if (!done) check_val("req_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    check_val("drain", sb_q.size(), 0);
  endtask

  task automatic check_flush_body();
    for (int i = 0; i < SETS; i++) begin
      @(negedge clk);
      check_val("flush_addr", bus.lutram_set_addr_out, i);
      check_val("flush_data", bus.lutram_write_element_out, 0);
      check_val("flush_ctl", {bus.lutram_access_en_out, bus.lutram_write_en_out,
                              bus.req_ready_out, bus.flush_done_out}, 4'b1100);
    end
    @(negedge clk);
    check_val("flush_done", bus.flush_done_out, 1);
    for (int s = 0; s < SETS; s++) ref_mem[s] = 3'b000;
  endtask

  task automatic flush_seq(input bit with_req, input logic [5:0] set);
    @(posedge clk); #1;
    bus.flush_in = 1'b1;
    if (with_req) begin
      bus.req_valid_in = 1'b1; bus.req_set_in = set; bus.req_hit_in = 1'b0; bus.req_way_in = 2'd3;
    end
    @(negedge clk);
    check_val("flush_entry_ready", bus.req_ready_out, 0);
    check_val("flush_entry_access", bus.lutram_access_en_out, 0);
    @(posedge clk); #1;
    bus.flush_in = 1'b0;
    check_flush_body();
    if (with_req) begin
      check_val("req_after_flush_ready", bus.req_ready_out, 1);
      if (bus.req_ready_out) push_exp(set, 1'b0, 2'd3);
      @(posedge clk); #1;
      bus.req_valid_in = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val(tag, {bus.req_ready_out, bus.resp_valid_out, bus.resp_way_out, bus.flush_done_out,
                    bus.lutram_access_en_out, bus.lutram_write_en_out,
                    bus.lutram_set_addr_out, bus.lutram_write_element_out}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    int unsigned pulses;
    cyc = 0; total = 0; bad = 0;
    lut_rd = '0;
    last_wr_addr = '0; last_wr_data = '0;
    for (int s = 0; s < SETS; s++) begin lut_mem[s] = '0; ref_mem[s] = '0; end
    rst_n = 1'b0;
    bus.req_valid_in = 1'b0; bus.req_set_in = '0; bus.req_hit_in = 1'b0;
    bus.req_way_in = '0; bus.flush_in = 1'b0;
    bus.req_valid_in = 1'b1;
    #2;
    check_outputs_zero("reset_outputs");
    bus.req_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_reset", bus.req_ready_out, 1);

    // Four misses on one set walk the victims 0,2,1,3.
    flush_seq(0, '0);
    for (int i = 0; i < 4; i++) send_req(6'd5, 1'b0, 2'd0);
    drain();

    flush_seq(0, '0);
    send_req(6'd9, 1'b1, 2'd2);
    send_req(6'd9, 1'b0, 2'd0);
    drain();

    // Continuous valid: ready alternates, sets 3/4 alternate per accept.
    acc = 0;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b1; bus.req_hit_in = 1'b0; bus.req_set_in = 6'd3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("ready_pattern", bus.req_ready_out, (i % 2) == 0);
      if (bus.req_ready_out) begin
        push_exp(bus.req_set_in, 1'b0, 2'd0);
        acc++;
      end
      @(posedge clk); #1;
      bus.req_set_in = (acc % 2) ? 6'd4 : 6'd3;
    end
    bus.req_valid_in = 1'b0;
    check_val("accept_count", acc, 4);
    drain();

    // Nonzero state on set 63, flush, then a miss returns to victim 0.
    send_req(6'd63, 1'b0, 2'd0);
    send_req(6'd63, 1'b1, 2'd3);
    drain();
    flush_seq(0, '0);
    send_req(6'd63, 1'b0, 2'd0);
    drain();

    // Flush and request together: flush wins, request follows.
    flush_seq(1, 6'd7);
    drain();

    // Flush pulse during UPDATE is held until the next IDLE cycle.
    @(posedge clk); #1;
    bus.req_valid_in = 1'b1; bus.req_set_in = 6'd9; bus.req_hit_in = 1'b1; bus.req_way_in = 2'd1;
    @(negedge clk);
    check_val("upd_accept_ready", bus.req_ready_out, 1);
    if (bus.req_ready_out) push_exp(6'd9, 1'b1, 2'd1);
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0; bus.flush_in = 1'b1;
    @(posedge clk); #1;
    bus.flush_in = 1'b0;
    @(negedge clk);
    check_val("pending_ready", bus.req_ready_out, 0);
    check_val("pending_access", bus.lutram_access_en_out, 0);
    check_flush_body();
    drain();
    send_req(6'd9, 1'b0, 2'd0);
    drain();

    // Reset at flush cycle 10 abandons the flush.
    @(posedge clk); #1;
    bus.flush_in = 1'b1;
    @(posedge clk); #1;
    bus.flush_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero("midflush_reset_outputs");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("ready_after_midflush_reset", bus.req_ready_out, 1);
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.flush_done_out) pulses++;
    end
    check_val("no_flush_done_after_reset", pulses, 0);

    flush_seq(0, '0);
    send_req(6'd5, 1'b0, 2'd0);
    send_req(6'd5, 1'b0, 2'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
